layer2_argmax: RTL and testbench
================================

Name: layer2_argmax

Overview:
- Downstream of the layer-2 MAC bank. Consumes the 10 accumulated class sums once accumulation completes.
- Captures all sums in one cycle so the MAC bank can be cleared and reused immediately.
- Scans the captured sums serially with a signed compare and reports the winning class index plus its score.
- Result is returned over a valid/ready handshake to the top-level result/display logic.

Parameters:
- NUM_CLASSES, 10, number of class sums (output neurons).
- SUM_W, `LAYER_2_OUT_BIT_WIDTH, width of each signed two's-complement sum.
- IDX_W, 4, class index width; must satisfy 2**IDX_W >= NUM_CLASSES.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- clr  in  1  asynchronous active-low reset.
- start  in  1  sums valid; sampled only when start_ready=1.
- start_ready  out  1  high only in IDLE.
- sumIn  in  NUM_CLASSES*SUM_W  packed sums; class m occupies bits [m*SUM_W +: SUM_W].
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- classOut  out  IDX_W  index of the maximum sum.
- maxOut  out  SUM_W  value of the maximum sum.
- busy  out  1  high in SCAN.

Behaviour:
- Reset (clr=0, async): state=IDLE. start_ready=1; out_valid=0, busy=0, classOut=0, maxOut=0. Sum bank, count and best registers=0. Reset mid-scan or mid-DONE aborts with no output.
- States: IDLE, SCAN, DONE.
- IDLE, start=1 at edge E0:
  - Capture all NUM_CLASSES sums into the internal bank.
  - best_val=sum[0], best_idx=0, cnt=1 -> SCAN.
  - sumIn is don't-care after E0.
- SCAN, one sum per cycle:
  - If bank[cnt] > best_val (signed, strict), load best_val=bank[cnt] and best_idx=cnt.
  - cnt increments.
  - On the edge that processes cnt=NUM_CLASSES-1: classOut/maxOut take the final best values, out_valid=1, -> DONE.
  - out_valid rises at edge E0+(NUM_CLASSES-1), i.e. E0+9 by default.
- Ties: strict compare, so the lowest index wins.
- DONE:
  - classOut, maxOut and out_valid stay stable until out_ready=1 at an edge.
  - On that edge out_valid=0 -> IDLE. classOut/maxOut retain their values until the next result.
- start is ignored outside IDLE (no queuing). out_ready is ignored when out_valid=0.
- start=1 in the IDLE cycle immediately after a handshake is accepted normally. Back-to-back throughput is one result per NUM_CLASSES+1 cycles with out_ready tied high.
- Arithmetic: pure signed compare, no widening or saturation; sums are taken as-is from the MAC bank.
- NUM_CLASSES=1 degenerate case: out_valid at E0+1 with classOut=0 (SCAN is a single pass-through cycle).

Decomposition:
- Shared package/include (GlobalVariables.v): NUM_CLASSES and IDX_W defaults, state encodings (IDLE=2'd0, SCAN=2'd1, DONE=2'd2), reuse of `LAYER_2_OUT_BIT_WIDTH.
- One sub-module: argmax_cmp.
  - Combinational signed compare-select.
  - Takes (best_val, best_idx, cand_val, cand_idx) and returns the new best pair.
  - Instantiated once inside the SCAN datapath.

Test Plan:
- Reset mid-scan: start, then clr=0 at E0+4 -> out_valid=0, classOut=0, maxOut=0, start_ready=1 immediately (asynchronously).
- Distinct maximum: sums {5,-3,17,2,0,9,-40,16,1,3}, out_ready=1 -> out_valid at E0+9 for one cycle; classOut=2, maxOut=17.
- Signed/negative and tie: all sums negative {-8,-2,-9,-2,-100,-5,-3,-2,-7,-6} -> classOut=1, maxOut=-2 (lowest index of the tie).
- Extremes: sum[9]=max positive (0111..1), sum[0]=min negative (1000..0), rest 0 -> classOut=9, maxOut=2**(SUM_W-1)-1.
- Backpressure and ignored start: out_ready=0 for 5 cycles after out_valid; pulse start during SCAN and DONE with different sums.
  - Result holds stable and no new capture occurs.
  - out_ready=1 -> out_valid drops next edge, start_ready=1.
- Back-to-back: two frames with out_ready tied 1 and start re-asserted in IDLE -> second out_valid exactly 11 cycles after the first, correct index for each frame.

Source files
------------

// File: rtl/layer2_argmax_pkg.sv
// Shared definitions for the layer-2 argmax block.
// Holds the default class count, class-index width and sum width (taken from
// the layer-2 output width macro), plus the FSM state encoding.
// The default sum width applies only when the build does not already define
// LAYER_2_OUT_BIT_WIDTH.
`ifndef LAYER_2_OUT_BIT_WIDTH
`define LAYER_2_OUT_BIT_WIDTH 16
`endif

package layer2_argmax_pkg;

  localparam int NUM_CLASSES_DEF = 10;
  localparam int IDX_W_DEF       = 4;
  localparam int SUM_W_DEF       = `LAYER_2_OUT_BIT_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/layer2_argmax_if.sv
// Bus between the layer-2 MAC bank / result logic and the argmax block.
//
// Handshake rules:
//   start/start_ready : the sums on sumIn are captured at a rising clock edge
//                       where start=1 and start_ready=1. start is ignored
//                       whenever start_ready=0 and is never queued.
//   out_valid/out_ready: classOut/maxOut are valid while out_valid=1. They
//                       hold stable until an edge where out_ready=1, which
//                       completes the transfer. out_ready is ignored while
//                       out_valid=0.
//
// Signals:
//   start       sums on sumIn are valid
//   start_ready block can accept a new set of sums
//   sumIn       packed sums, class m in bits [m*SUM_W +: SUM_W]
//   out_valid   result valid
//   out_ready   consumer accepts the result
//   classOut    index of the maximum sum
//   maxOut      value of the maximum sum
//   busy        scan in progress
//
// Modports: master = producer/consumer side, slave = the argmax block.
interface layer2_argmax_if
  import layer2_argmax_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int SUM_W       = SUM_W_DEF,
  parameter int IDX_W       = IDX_W_DEF
);

  logic                         start;
  logic                         start_ready;
  logic [NUM_CLASSES*SUM_W-1:0] sumIn;
  logic                         out_valid;
  logic                         out_ready;
  logic [IDX_W-1:0]             classOut;
  logic [SUM_W-1:0]             maxOut;
  logic                         busy;

  modport master (
    output start, sumIn, out_ready,
    input  start_ready, out_valid, classOut, maxOut, busy
  );

  modport slave (
    input  start, sumIn, out_ready,
    output start_ready, out_valid, classOut, maxOut, busy
  );

endinterface

// File: rtl/layer2_argmax_argmax_cmp.sv
// Combinational signed compare-select used by the argmax scan.
// Ports:
//   best_val/best_idx : current best pair
//   cand_val/cand_idx : candidate pair
//   new_val/new_idx   : updated best pair
// The compare is strict, so an equal candidate never replaces the current
// best; scanning in ascending index order therefore keeps the lowest index
// on ties.
module argmax_cmp #(
  parameter int SUM_W = 16,
  parameter int IDX_W = 4
) (
  input  logic signed [SUM_W-1:0] best_val,
  input  logic        [IDX_W-1:0] best_idx,
  input  logic signed [SUM_W-1:0] cand_val,
  input  logic        [IDX_W-1:0] cand_idx,
  output logic signed [SUM_W-1:0] new_val,
  output logic        [IDX_W-1:0] new_idx
);

  always_comb begin
    new_val = best_val;
    new_idx = best_idx;
    if (cand_val > best_val) begin
      new_val = cand_val;
      new_idx = cand_idx;
    end
  end

endmodule

// File: rtl/layer2_argmax.sv
// Layer-2 argmax: captures all class sums in one cycle, scans them serially
// with a signed compare and returns the winning class index and its score.
// Ports:
//   clk       clock, rising edge
//   clr       asynchronous active-low reset
//   bus       layer2_argmax_if slave (start/sumIn in, result handshake out)
//   state_dbg current FSM state
module layer2_argmax
  import layer2_argmax_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int SUM_W       = SUM_W_DEF,
  parameter int IDX_W       = IDX_W_DEF
) (
  input  logic                  clk,
  input  logic                  clr,
  layer2_argmax_if.slave        bus,
  output state_t                state_dbg
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t state, state_nx;

  logic signed [SUM_W-1:0] bank [NUM_CLASSES];
  logic        [IDX_W-1:0] cnt;
  logic signed [SUM_W-1:0] best_val;
  logic        [IDX_W-1:0] best_idx;
  logic        [IDX_W-1:0] class_q;
  logic signed [SUM_W-1:0] max_q;

  logic signed [SUM_W-1:0] cand_val;
  logic signed [SUM_W-1:0] new_val;
  logic        [IDX_W-1:0] new_idx;
  logic                    scan_last;

  logic start_ready_c;
  logic out_valid_c;
  logic busy_c;

  // With a single class the scan cycle has no candidate beyond sum[0];
  // feeding back best_val makes that cycle a pass-through.
  assign cand_val  = (cnt <= LAST_IDX) ? bank[cnt] : best_val;
  assign scan_last = (cnt >= LAST_IDX);

  argmax_cmp #(
    .SUM_W (SUM_W),
    .IDX_W (IDX_W)
  ) u_cmp (
    .best_val (best_val),
    .best_idx (best_idx),
    .cand_val (cand_val),
    .cand_idx (cnt),
    .new_val  (new_val),
    .new_idx  (new_idx)
  );

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (bus.start)     state_nx = ST_SCAN;
      ST_SCAN: if (scan_last)     state_nx = ST_DONE;
      ST_DONE: if (bus.out_ready) state_nx = ST_IDLE;
      default:                    state_nx = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    start_ready_c = 1'b0;
    out_valid_c   = 1'b0;
    busy_c        = 1'b0;
    unique case (state)
      ST_IDLE: start_ready_c = 1'b1;
      ST_SCAN: busy_c        = 1'b1;
      ST_DONE: out_valid_c   = 1'b1;
      default: start_ready_c = 1'b0;
    endcase
  end

  // Capture and scan datapath
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int m = 0; m < NUM_CLASSES; m++) bank[m] <= '0;
      cnt      <= '0;
      best_val <= '0;
      best_idx <= '0;
      class_q  <= '0;
      max_q    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            for (int m = 0; m < NUM_CLASSES; m++)
              bank[m] <= bus.sumIn[m*SUM_W +: SUM_W];
            best_val <= bus.sumIn[SUM_W-1:0];
            best_idx <= '0;
            cnt      <= IDX_W'(1);
          end
        end
        ST_SCAN: begin
          best_val <= new_val;
          best_idx <= new_idx;
          cnt      <= cnt + 1'b1;
          if (scan_last) begin
            class_q <= new_idx;
            max_q   <= new_val;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.start_ready = start_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.busy        = busy_c;
  assign bus.classOut    = class_q;
  assign bus.maxOut      = max_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_layer2_argmax.sv
// Bench for layer2_argmax: directed frames with hand-computed results plus
// randomized start/out_ready/sum traffic, all compared every cycle against
// a transaction-level reference model.
module tb_layer2_argmax;
  import layer2_argmax_pkg::*;

  localparam int NC = 10;
  localparam int SW = SUM_W_DEF;
  localparam int IW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  layer2_argmax_if #(.NUM_CLASSES(NC), .SUM_W(SW), .IDX_W(IW)) bus ();
  state_t dbg_state;

  layer2_argmax #(.NUM_CLASSES(NC), .SUM_W(SW), .IDX_W(IW)) dut (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus),
    .state_dbg (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Argmax from the rules: find the largest signed value, then the lowest
  // index holding it.
  function automatic void ref_argmax(input logic [NC*SW-1:0] s,
                                     output logic [IW-1:0] ci,
                                     output logic signed [SW-1:0] mv);
    logic signed [SW-1:0] v;
    mv = s[SW-1:0];
    for (int m = 1; m < NC; m++) begin
      v = s[m*SW +: SW];
      if (v > mv) mv = v;
    end
    ci = '0;
    for (int m = NC - 1; m >= 0; m--) begin
      v = s[m*SW +: SW];
      if (v == mv) ci = IW'(m);
    end
  endfunction

  // Transaction view: idle -> result after NC-1 further edges -> held until
  // accepted.
  bit                   m_idle  = 1'b1;
  bit                   m_valid = 1'b0;
  int                   m_wait  = 0;
  logic [IW-1:0]        m_pend_c, m_class = '0;
  logic signed [SW-1:0] m_pend_v, m_max = '0;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_idle = 1'b1; m_valid = 1'b0; m_wait = 0; m_class = '0; m_max = '0;
    end else if (m_idle) begin
      if (bus.start) begin
        ref_argmax(bus.sumIn, m_pend_c, m_pend_v);
        m_idle = 1'b0;
        m_wait = NC - 1;
      end
    end else if (!m_valid) begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid = 1'b1; m_class = m_pend_c; m_max = m_pend_v;
      end
    end else if (bus.out_ready) begin
      m_valid = 1'b0; m_idle = 1'b1;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    check("cmp_start_ready", bus.start_ready, m_idle);
    check("cmp_out_valid",   bus.out_valid,   m_valid);
    check("cmp_busy",        bus.busy,        !m_idle && !m_valid);
    check("cmp_classOut",    bus.classOut,    m_class);
    check("cmp_maxOut",      $signed(bus.maxOut), m_max);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NC*SW-1:0] pack(input int v[NC]);
    logic [NC*SW-1:0] r;
    for (int m = 0; m < NC; m++) r[m*SW +: SW] = v[m][SW-1:0];
    return r;
  endfunction

  task automatic send_frame(input logic [NC*SW-1:0] s, output int e0);
    check("pre_start_ready", bus.start_ready, 1);
    bus.sumIn = s;
    bus.start = 1'b1;
    tick();
    e0 = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(output int t);
    bit found = 1'b0;
    t = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid === 1'b1) begin
        found = 1'b1;
        t = cyc;
        break;
      end
    end
    check("wait_valid_timeout", found, 1);
  endtask

  // ---------------- stimulus ----------------
  int vals[NC];
  int e0, t1, t2;
  bit saw_valid;

  initial begin
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    bus.sumIn     = '0;
    clr           = 1'b0;
    repeat (3) tick();
    check("rst_start_ready", bus.start_ready, 1);
    check("rst_out_valid",   bus.out_valid,   0);
    check("rst_busy",        bus.busy,        0);
    check("rst_classOut",    bus.classOut,    0);
    check("rst_maxOut",      $signed(bus.maxOut), 0);
    clr = 1'b1;
    tick();

    // Distinct maximum, one-cycle valid with out_ready high
    bus.out_ready = 1'b1;
    vals = '{5, -3, 17, 2, 0, 9, -40, 16, 1, 3};
    send_frame(pack(vals), e0);
    wait_valid(t1);
    check("dist_latency",  t1 - e0, 9);
    check("dist_classOut", bus.classOut, 2);
    check("dist_maxOut",   $signed(bus.maxOut), 17);
    tick();
    check("dist_valid_drop", bus.out_valid, 0);

    // All negative with a three-way tie on -2
    vals = '{-8, -2, -9, -2, -100, -5, -3, -2, -7, -6};
    send_frame(pack(vals), e0);
    wait_valid(t1);
    check("neg_classOut", bus.classOut, 1);
    check("neg_maxOut",   $signed(bus.maxOut), -2);
    tick();

    // Extremes
    vals = '{-(2**(SW-1)), 0, 0, 0, 0, 0, 0, 0, 0, 2**(SW-1) - 1};
    send_frame(pack(vals), e0);
    wait_valid(t1);
    check("ext_classOut", bus.classOut, 9);
    check("ext_maxOut",   $signed(bus.maxOut), 2**(SW-1) - 1);
    tick();

    // Backpressure with start pulses during SCAN and DONE
    bus.out_ready = 1'b0;
    vals = '{1, 2, 3, 4, 50, 5, 6, 7, 8, 9};
    send_frame(pack(vals), e0);
    repeat (3) tick();
    vals = '{100, 100, 100, 100, 100, 100, 100, 100, 100, 100};
    bus.sumIn = pack(vals);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_valid(t1);
    check("bp_latency", t1 - e0, 9);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        vals = '{0, 0, 0, 0, 0, 0, 0, 99, 0, 0};
        bus.sumIn = pack(vals);
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_class", bus.classOut, 4);
      check("bp_hold_max",   $signed(bus.maxOut), 50);
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_valid", bus.out_valid, 0);
    check("bp_release_ready", bus.start_ready, 1);

    // Back-to-back frames
    vals = '{0, 1, 2, 3, 4, 5, 6, 70, 8, 9};
    send_frame(pack(vals), e0);
    wait_valid(t1);
    check("b2b_f1_class", bus.classOut, 7);
    tick();
    vals = '{33, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    send_frame(pack(vals), e0);
    wait_valid(t2);
    check("b2b_spacing",  t2 - t1, 11);
    check("b2b_f2_class", bus.classOut, 0);
    check("b2b_f2_max",   $signed(bus.maxOut), 33);
    tick();

    // Reset in the middle of a scan
    vals = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 2};
    send_frame(pack(vals), e0);
    repeat (3) tick();
    @(posedge clk);
    #1 clr = 1'b0;
    #1;
    check("mid_rst_out_valid",   bus.out_valid,   0);
    check("mid_rst_start_ready", bus.start_ready, 1);
    check("mid_rst_busy",        bus.busy,        0);
    check("mid_rst_classOut",    bus.classOut,    0);
    check("mid_rst_maxOut",      $signed(bus.maxOut), 0);
    repeat (2) tick();
    clr = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.out_valid === 1'b1) saw_valid = 1'b1;
    end
    check("mid_rst_no_result", saw_valid, 0);

    // Randomized traffic, including small-range sums to force ties
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < NC; m++) begin
        if ($urandom_range(0, 1) == 0) vals[m] = int'($urandom_range(0, 6)) - 3;
        else                           vals[m] = int'($urandom_range(0, 65535)) - 32768;
      end
      bus.sumIn     = pack(vals);
      bus.start     = ($urandom_range(0, 2) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (15) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
